// File: rtl/pc_unit.sv
// Program counter for the single-cycle fetch path.
// Next-PC select, sticky halt/error flags and a saturating retire counter.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             PCWre,
  input  logic [1:0]       PcSrc,
  input  logic [31:0]      imm_ext,
  input  logic [25:0]      jaddr,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc_plus4,
  output logic             halted,
  output logic             pc_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [31:0] PC_INIT =
    {RESET_PC[31:2], 2'b00};

  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      pc_nxt;
  logic [31:0]      br;
  logic [31:0]      jmp;
  logic             err_nxt;
  logic [CNT_W-1:0] ret_nxt;
  logic             ret_full;

  assign pc_plus4 = pc_out + 32'd4;
  assign br       = pc_plus4 + (imm_ext << 2);
  assign jmp      = {pc_plus4[31:28], jaddr, 2'b00};
  assign halted   = (state == HALT);
  assign ret_full = &retired;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_out;
    err_nxt   = pc_err;
    ret_nxt   = retired;
    unique case (state)
      RUN: begin
        if (!PCWre) begin
          state_nxt = HALT;
        end else begin
          unique case (PcSrc)
            2'b00: pc_nxt = pc_plus4;
            2'b01: pc_nxt = br;
            2'b10: pc_nxt = jmp;
            2'b11: err_nxt = 1'b1;
          endcase
          // Reserved select is not an accepted update.
          if (PcSrc != 2'b11 && !ret_full)
            ret_nxt = retired + CNT_ONE;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= RUN;
      pc_out  <= PC_INIT;
      pc_err  <= 1'b0;
      retired <= '0;
    end else begin
      state   <= state_nxt;
      pc_out  <= pc_nxt;
      pc_err  <= err_nxt;
      retired <= ret_nxt;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed steps then random traffic,
// two instances (default and small-counter/odd reset PC) vs a behavioural model.
module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWre;
  logic [1:0]  PcSrc;
  logic [31:0] imm_ext;
  logic [25:0] jaddr;

  logic [31:0] pc_a, p4_a, pc_b, p4_b;
  logic        halt_a, err_a, halt_b, err_b;
  logic [31:0] ret_a;
  logic [3:0]  ret_b;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    bit          halted;
    bit          err;
    longint      ret;
  } model_t;

  model_t ma, mb;

  pc_unit u_a (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre),
    .PcSrc(PcSrc), .imm_ext(imm_ext),
    .jaddr(jaddr), .pc_out(pc_a),
    .pc_plus4(p4_a), .halted(halt_a),
    .pc_err(err_a), .retired(ret_a)
  );

  pc_unit #(
    .RESET_PC(32'h0000_1003), .CNT_W(4)
  ) u_b (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre),
    .PcSrc(PcSrc), .imm_ext(imm_ext),
    .jaddr(jaddr), .pc_out(pc_b),
    .pc_plus4(p4_b), .halted(halt_b),
    .pc_err(err_b), .retired(ret_b)
  );

  always #5 CLK = ~CLK;

  function automatic model_t mstep(
    input model_t m, input logic [31:0] rpc,
    input longint rmax);
    logic [31:0] seq;
    model_t r;
    r = m;
    seq = m.pc + 32'd4;
    if (Reset) begin
      r.pc = rpc & 32'hFFFF_FFFC;
      r.halted = 0; r.err = 0; r.ret = 0;
    end else if (m.halted) begin
      r = m;
    end else if (!PCWre) begin
      r.halted = 1;
    end else if (PcSrc == 2'd3) begin
      r.err = 1;
    end else begin
      if (PcSrc == 2'd0) r.pc = seq;
      if (PcSrc == 2'd1) r.pc = seq + imm_ext * 32'd4;
      if (PcSrc == 2'd2)
        r.pc = (seq & 32'hF000_0000) | ({6'd0, jaddr} * 32'd4);
      if (m.ret < rmax) r.ret = m.ret + 1;
    end
    return r;
  endfunction

  task automatic check(input string tag,
    input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a.pc", pc_a, ma.pc);
    check("a.pc4", p4_a, ma.pc + 32'd4);
    check("a.halt", {31'd0, halt_a}, {31'd0, ma.halted});
    check("a.err", {31'd0, err_a}, {31'd0, ma.err});
    check("a.ret", ret_a, 32'(ma.ret));
    check("b.pc", pc_b, mb.pc);
    check("b.pc4", p4_b, mb.pc + 32'd4);
    check("b.halt", {31'd0, halt_b}, {31'd0, mb.halted});
    check("b.err", {31'd0, err_b}, {31'd0, mb.err});
    check("b.ret", {28'd0, ret_b}, 32'(mb.ret));
  endtask

  task automatic step(input logic rst, input logic we,
    input logic [1:0] src, input logic [31:0] imm,
    input logic [25:0] ja);
    Reset = rst; PCWre = we; PcSrc = src;
    imm_ext = imm; jaddr = ja;
    @(posedge CLK);
    ma = mstep(ma, 32'h0, 64'hFFFF_FFFF);
    mb = mstep(mb, 32'h0000_1003, 64'd15);
    #1;
    check_all();
  endtask

  initial begin
    ma = '{pc: 0, halted: 0, err: 0, ret: 0};
    mb = ma;
    Reset = 1; PCWre = 1; PcSrc = 0;
    imm_ext = 0; jaddr = 0;
    #1;
    // reset
    step(1, 1, 0, 0, 0);
    check("rst.pc", pc_a, 32'h0);
    check("rst.pcb", pc_b, 32'h1000);
    // sequential
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("seq3.pc", pc_a, 32'hC);
    check("seq3.ret", ret_a, 32'd3);
    step(0, 1, 0, 0, 0);
    // branches
    step(0, 1, 1, 32'hFFFF_FFFE, 0);
    check("br.neg", pc_a, 32'hC);
    step(0, 1, 1, 32'h0000_0003, 0);
    check("br.pos", pc_a, 32'h1C);
    step(0, 1, 1, 32'h2000_0008, 0);
    check("br.far", pc_a, 32'h8000_0040);
    // jump keeps upper nibble of pc+4
    step(0, 1, 2, 0, 26'h10);
    check("jmp", pc_a, 32'h8000_0040);
    step(0, 1, 1, 32'h1FFF_FFEE, 0);
    check("br.top", pc_a, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0);
    check("wrap", pc_a, 32'h0);
    // reserved select
    step(0, 1, 3, 32'h5, 26'h5);
    check("rsv.pc", pc_a, 32'h0);
    check("rsv.err", {31'd0, err_a}, 32'd1);
    step(0, 1, 0, 0, 0);
    check("rsv.adv", pc_a, 32'h4);
    // halt at 0x20
    step(0, 1, 2, 0, 26'h8);
    check("j20", pc_a, 32'h20);
    step(0, 0, 3, 0, 0);
    check("halt", {31'd0, halt_a}, 32'd1);
    for (int i = 0; i < 10; i++)
      step(0, 1'($urandom), 2'($urandom), $urandom, 26'($urandom));
    check("halt.pc", pc_a, 32'h20);
    step(1, 1, 0, 0, 0);
    check("hrst.pc", pc_a, 32'h0);
    check("hrst.ret", ret_a, 32'd0);
    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    check("sat", {28'd0, ret_b}, 32'hF);
    check("sat.a", ret_a, 32'd20);
    step(1, 0, 0, 0, 0);
    check("rw.halt", {31'd0, halt_b}, 32'd0);
    check("rw.pc", pc_b, 32'h1000);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 24) != 0),
           ($urandom_range(0, 9) == 0) ? 2'd3
             : 2'($urandom_range(0, 2)),
           $urandom, 26'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
